tx_mutex_arbiter: RTL

- Grants exclusive ownership of the shared PHY-TX FIFOs (ports 0..NUM_PORT-1) to the MAC switch engines, one engine per ingress PHY.
- Each engine drives a one-hot-or-multi-hot mutex request and waits until its grant vector equals its request. Grants are atomic (all requested ports or none), which prevents deadlock between engines that broadcast.
- Round-robin selection with a head reservation guarantees that no engine starves.

---
 rtl/tx_mutex_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tx_mutex_arbiter.sv
// Atomic multi-port mutex arbiter for the shared PHY-TX FIFOs.
// Round-robin selection with a head reservation, so a broadcast requester cannot be starved.
module tx_mutex_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_PORT = 4,
  parameter int MAX_HOLD = 4096,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*NUM_PORT-1:0] mutex_req,
  output logic [NUM_REQ*NUM_PORT-1:0] mutex_val,
  output logic [NUM_PORT-1:0]         port_busy,
  output logic [NUM_REQ-1:0]          proto_err,
  output logic [NUM_REQ-1:0]          timeout_err,
  input  logic                        err_clr,
  output logic [PTR_W-1:0]            o_dbg_rr_ptr,
  output logic [2*NUM_REQ-1:0]        o_dbg_state
);

  // Handshake: requester i holds mutex_req[i] and owns the ports once its mutex_val slice
  // equals it (all bits at once); clearing request bits releases them at the next edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } req_state_e;

  logic [NUM_REQ*NUM_PORT-1:0] r_val;
  logic [NUM_PORT-1:0]         r_busy;
  logic [NUM_REQ-1:0]          r_perr;
  logic [NUM_REQ-1:0]          r_tmo;
  logic [PTR_W-1:0]            r_rr;
  logic [CNT_W-1:0]            r_cnt [NUM_REQ];

  logic [NUM_PORT-1:0]         w_req [NUM_REQ];
  logic [NUM_PORT-1:0]         w_val [NUM_REQ];
  req_state_e                  w_state [NUM_REQ];
  logic [NUM_REQ-1:0]          w_elig;
  logic [NUM_PORT-1:0]         w_owned;
  logic [NUM_PORT-1:0]         w_reserved;
  logic                        w_gnt_vld;
  logic [PTR_W-1:0]            w_gnt_idx;
  logic [NUM_REQ*NUM_PORT-1:0] w_val_nxt;
  logic [NUM_PORT-1:0]         w_busy_nxt;
  logic [NUM_REQ-1:0]          w_perr_set;
  logic [NUM_REQ-1:0]          w_tmo_set;
  logic [CNT_W-1:0]            w_cnt_nxt [NUM_REQ];
  logic [PTR_W-1:0]            w_rr_nxt;

  always_comb begin
    w_owned     = '0;
    o_dbg_state = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i] = mutex_req[i*NUM_PORT +: NUM_PORT];
      w_val[i] = r_val[i*NUM_PORT +: NUM_PORT];
      w_owned  = w_owned | w_val[i];
      if (w_val[i] != '0)      w_state[i] = ST_HOLD;
      else if (w_req[i] != '0) w_state[i] = ST_WAIT;
      else                     w_state[i] = ST_IDLE;
      o_dbg_state[i*2 +: 2] = w_state[i];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = (w_state[i] == ST_WAIT) && ((w_req[i] & w_owned) == '0);
    end
  end

  // A blocked waiting head reserves its ports so later requesters cannot keep them busy.
  always_comb begin
    int j;
    j          = 0;
    w_reserved = ((w_state[r_rr] == ST_WAIT) && !w_elig[r_rr]) ? w_req[r_rr] : '0;
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = r_rr;
    if (w_elig[r_rr]) begin
      w_gnt_vld = 1'b1;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        j = int'(r_rr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!w_gnt_vld && w_elig[j] && ((w_req[j] & w_reserved) == '0)) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = PTR_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_val_nxt  = '0;
    w_busy_nxt = '0;
    w_perr_set = '0;
    w_tmo_set  = '0;
    w_cnt_nxt  = '{default: '0};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_vld && (w_gnt_idx == PTR_W'(i))) w_val_nxt[i*NUM_PORT +: NUM_PORT] = w_req[i];
      else w_val_nxt[i*NUM_PORT +: NUM_PORT] = w_val[i] & w_req[i];
      w_busy_nxt = w_busy_nxt | w_val_nxt[i*NUM_PORT +: NUM_PORT];
      if (w_state[i] == ST_HOLD) begin
        w_perr_set[i] = (w_req[i] & ~w_val[i]) != '0;
        if (r_cnt[i] == CNT_W'(MAX_HOLD)) w_cnt_nxt[i] = r_cnt[i];
        else                              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        w_tmo_set[i] = (w_cnt_nxt[i] == CNT_W'(MAX_HOLD));
      end
    end
    w_rr_nxt = r_rr;
    if ((w_state[r_rr] != ST_WAIT) || (w_gnt_vld && (w_gnt_idx == r_rr))) begin
      w_rr_nxt = (r_rr == PTR_W'(NUM_REQ - 1)) ? '0 : r_rr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= '0;
      r_busy <= '0;
      r_perr <= '0;
      r_tmo  <= '0;
      r_rr   <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_val  <= w_val_nxt;
      r_busy <= w_busy_nxt;
      r_perr <= (err_clr ? '0 : r_perr) | w_perr_set;
      r_tmo  <= (err_clr ? '0 : r_tmo) | w_tmo_set;
      r_rr   <= w_rr_nxt;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign mutex_val    = r_val;
  assign port_busy    = r_busy;
  assign proto_err    = r_perr;
  assign timeout_err  = r_tmo;
  assign o_dbg_rr_ptr = r_rr;

endmodule
